// File: rtl/sample_byte_tx.sv
// sample_byte_tx: byte-serial sample transmitter.
// 16-bit samples are accepted over valid/ready into a small FIFO. Each sample
// is sent MSB first as two single-cycle strobes on an 8-bit bus. An optional
// idle gap follows every strobe. The strobe for a freshly popped sample is
// registered on the pop edge, so IDLE adds no dead cycle between samples.
module sample_byte_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [7:0]                    byte_out,
    output logic                          byte_valid,
    output logic                          sample_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ZERO = LW'(0);
    localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
    // Gap counter counts down to zero, so it is loaded with one less than the gap length.
    localparam logic [3:0]    GAP_LOAD = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MSB    = 3'd1,
        ST_GAP_HI = 3'd2,
        ST_LSB    = 3'd3,
        ST_GAP_LO = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             gap_q, gap_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d;
    logic [7:0]             byte_q, byte_d;
    logic                   valid_q, valid_d;
    logic                   done_q, done_d;

    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]          level_q;

    logic                   push_s, pop_s, empty_s, full_s;
    logic [DATA_WIDTH-1:0]  head_s;

    assign empty_s      = (level_q == LVL_ZERO);
    assign full_s       = (level_q == LVL_FULL);
    assign push_s       = sample_valid && !full_s;
    assign head_s       = mem_q[rd_ptr_q];

    assign sample_ready = !full_s;
    assign fifo_level   = level_q;
    assign busy         = !empty_s || (state_q != ST_IDLE);
    assign byte_out     = byte_q;
    assign byte_valid   = valid_q;
    assign sample_done  = done_q;

    // FIFO storage: written on every accepted push, never needs reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= sample_in;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + LVL_ONE;
                2'b01:   level_q <= level_q - LVL_ONE;
                default: level_q <= level_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; pops happen only where the FSM decides to start a new sample.
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_MSB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MSB: begin
                if (HAS_GAP) begin
                    state_d = ST_GAP_HI;
                end else begin
                    state_d = ST_LSB;
                end
            end
            ST_GAP_HI: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_LSB;
                end else begin
                    state_d = ST_GAP_HI;
                end
            end
            ST_LSB: begin
                if (HAS_GAP) begin
                    state_d = ST_GAP_LO;
                end else if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_MSB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP_LO: begin
                if (gap_q != 4'd0) begin
                    state_d = ST_GAP_LO;
                end else if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_d = ST_MSB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output next-values keyed on the state being entered, so strobes are registered.
    always_comb begin
        hold_d  = hold_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        gap_d   = gap_q;
        case (state_d)
            ST_MSB: begin
                hold_d  = head_s;
                byte_d  = head_s[15:8];
                valid_d = 1'b1;
            end
            ST_LSB: begin
                byte_d  = hold_q[7:0];
                valid_d = 1'b1;
                done_d  = 1'b1;
            end
            ST_GAP_HI, ST_GAP_LO: begin
                if (state_q == state_d) begin
                    gap_d = gap_q - 4'd1;
                end else begin
                    gap_d = GAP_LOAD;
                end
            end
            default: begin
                gap_d = gap_q;
            end
        endcase
    end

    // Output, holding and gap-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            gap_q   <= 4'd0;
        end else begin
            hold_q  <= hold_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_sample_byte_tx.sv
// Bench for sample_byte_tx: two instances (no gap and a 3-cycle gap) are
// checked every cycle against a timeline model of the link, with directed
// scenarios and a randomized phase, plus a behavioural loopback receiver.
module tb_sample_byte_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [15:0] d0 = 16'h0000, d1 = 16'h0000;
    logic        rdy0, bv0, sd0, busy0, rdy1, bv1, sd1, busy1;
    logic [7:0]  bo0, bo1;
    logic [2:0]  lvl0, lvl1;

    sample_byte_tx #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_in(d0), .sample_valid(v0),
        .sample_ready(rdy0), .byte_out(bo0), .byte_valid(bv0),
        .sample_done(sd0), .busy(busy0), .fifo_level(lvl0));

    sample_byte_tx #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_in(d1), .sample_valid(v1),
        .sample_ready(rdy1), .byte_out(bo1), .byte_valid(bv1),
        .sample_done(sd1), .busy(busy1), .fifo_level(lvl1));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // A sample popped at edge P strobes its MSB at P, its LSB at P+1+G, and the
    // next pop may happen no earlier than P+2+2G.
    int          cyc = 0;
    logic [15:0] mq [2][8];
    int          mcnt [2];
    int          next_pop [2];
    bit          lsb_pend [2];
    int          lsb_edge [2];
    logic [7:0]  lsb_byte [2];
    logic [7:0]  e_byte [2];
    bit          e_valid [2], e_done [2], e_busy [2], e_ready [2], acc [2];
    int          e_level [2];

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; next_pop[k] = 0; lsb_pend[k] = 0; lsb_edge[k] = 0;
            lsb_byte[k] = 8'h00; e_byte[k] = 8'h00; e_valid[k] = 0; e_done[k] = 0;
            e_busy[k] = 0; e_ready[k] = 1; e_level[k] = 0; acc[k] = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                model_reset();
            end else begin
                cyc++;
                for (int k = 0; k < 2; k++) begin
                    bit          vin;
                    logic [15:0] din, s;
                    bit          ready_pre;
                    int          g;
                    g = gap_of(k);
                    vin = (k == 0) ? v0 : v1;
                    din = (k == 0) ? d0 : d1;
                    ready_pre = (mcnt[k] < 4);
                    e_valid[k] = 0;
                    e_done[k] = 0;
                    if (mcnt[k] > 0 && cyc >= next_pop[k]) begin
                        s = mq[k][0];
                        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
                        mcnt[k]--;
                        e_valid[k] = 1;
                        e_byte[k] = s[15:8];
                        lsb_pend[k] = 1;
                        lsb_edge[k] = cyc + 1 + g;
                        lsb_byte[k] = s[7:0];
                        next_pop[k] = cyc + 2 + 2 * g;
                    end else if (lsb_pend[k] && cyc == lsb_edge[k]) begin
                        e_valid[k] = 1;
                        e_done[k] = 1;
                        e_byte[k] = lsb_byte[k];
                        lsb_pend[k] = 0;
                    end
                    acc[k] = vin && ready_pre;
                    if (acc[k]) begin
                        mq[k][mcnt[k]] = din;
                        mcnt[k]++;
                    end
                    e_level[k] = mcnt[k];
                    e_ready[k] = (mcnt[k] < 4);
                    e_busy[k] = (mcnt[k] > 0) || (cyc < next_pop[k]);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("byte_valid0", bv0, e_valid[0]);
            chk("byte_out0", bo0, e_byte[0]);
            chk("sample_done0", sd0, e_done[0]);
            chk("busy0", busy0, e_busy[0]);
            chk("ready0", rdy0, e_ready[0]);
            chk("level0", lvl0, e_level[0]);
            chk("byte_valid1", bv1, e_valid[1]);
            chk("byte_out1", bo1, e_byte[1]);
            chk("sample_done1", sd1, e_done[1]);
            chk("busy1", busy1, e_busy[1]);
            chk("ready1", rdy1, e_ready[1]);
            chk("level1", lvl1, e_level[1]);
        end
    end

    // ---------------- strobe logs and loopback receiver ----------------
    logic [7:0]  lg0 [$], lg1 [$];
    int          lc0 [$], lc1 [$];
    logic [15:0] rx_q [$];
    bit          rx_have = 0;
    logic [7:0]  rx_msb = 8'h00;
    int          maxlvl1 = 0;
    bit          saw_full1 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                rx_have = 0;
            end else begin
                if (bv0 === 1'b1) begin
                    lg0.push_back(bo0);
                    lc0.push_back(cyc);
                    if (!rx_have) begin
                        rx_msb = bo0;
                        rx_have = 1;
                    end else begin
                        rx_q.push_back({rx_msb, bo0});
                        rx_have = 0;
                        chk("rx_write_on_lsb_done", sd0, 1'b1);
                    end
                end
                if (bv1 === 1'b1) begin
                    lg1.push_back(bo1);
                    lc1.push_back(cyc);
                end
                if (int'(lvl1) > maxlvl1) maxlvl1 = int'(lvl1);
                if (lvl1 == 3'd4 && rdy1 == 1'b0) saw_full1 = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and hold it until the model reports it accepted.
    task automatic send(input int k, input logic [15:0] data);
        bit ok;
        ok = 0;
        if (k == 0) begin v0 = 1'b1; d0 = data; end
        else begin v1 = 1'b1; d1 = data; end
        for (int n = 0; n < 60; n++) begin
            step();
            if (acc[k]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: inst %0d sample %h not accepted", k, data);
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            step();
            if (!e_busy[0] && !e_busy[1]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL drain_timeout: model still busy");
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n0;
        logic [15:0] s;
        repeat (3) step();
        chk("rst_ready0", rdy0, 1'b1);   chk("rst_level0", lvl0, 3'd0);
        chk("rst_valid0", bv0, 1'b0);    chk("rst_byte0", bo0, 8'h00);
        chk("rst_busy0", busy0, 1'b0);   chk("rst_done0", sd0, 1'b0);
        chk("rst_ready1", rdy1, 1'b1);   chk("rst_level1", lvl1, 3'd0);
        chk("rst_valid1", bv1, 1'b0);    chk("rst_busy1", busy1, 1'b0);
        rst_n = 1'b1;
        step();

        // single sample, no gap
        send(0, 16'hA55A); v0 = 1'b0;
        step(); chk("single_msb_valid", bv0, 1'b1); chk("single_msb_byte", bo0, 8'hA5); chk("single_msb_done", sd0, 1'b0);
        step(); chk("single_lsb_valid", bv0, 1'b1); chk("single_lsb_byte", bo0, 8'h5A); chk("single_lsb_done", sd0, 1'b1);
        step(); chk("single_after_valid", bv0, 1'b0); chk("single_after_busy", busy0, 1'b0); chk("single_after_byte", bo0, 8'h5A);

        // back-to-back pushes give eight contiguous strobes
        lg0.delete(); lc0.delete();
        for (int i = 0; i < 4; i++) begin
            s = {8'(2 * i + 1), 8'(2 * i + 2)};
            send(0, s);
        end
        v0 = 1'b0;
        drain();
        chk("b2b_count", lg0.size(), 8);
        for (int i = 0; i < lg0.size() && i < 8; i++) begin
            chk("b2b_byte", lg0[i], 8'(i + 1));
            chk("b2b_contiguous", lc0[i] - lc0[0], i);
        end

        // backpressure on the gapped instance: six samples, valid held high
        lg1.delete(); lc1.delete(); maxlvl1 = 0; saw_full1 = 0;
        for (int i = 0; i < 6; i++) begin
            s = 16'hA0B0 + 16'(i) * 16'h0101;
            send(1, s);
        end
        v1 = 1'b0;
        drain();
        chk("bp_max_level", maxlvl1, 4);
        chk("bp_ready_low_when_full", saw_full1, 1'b1);
        chk("bp_count", lg1.size(), 12);
        for (int i = 0; i < lg1.size() && i < 12; i++) begin
            s = 16'hA0B0 + 16'(i / 2) * 16'h0101;
            chk("bp_order", lg1[i], (i % 2 == 0) ? s[15:8] : s[7:0]);
        end

        // gap spacing
        lg1.delete(); lc1.delete();
        send(1, 16'hBEEF); send(1, 16'h1111); v1 = 1'b0;
        drain();
        chk("gap_count", lg1.size(), 4);
        if (lg1.size() == 4) begin
            chk("gap_msb", lg1[0], 8'hBE); chk("gap_lsb", lg1[1], 8'hEF);
            chk("gap_msb_to_lsb", lc1[1] - lc1[0], 4);
            chk("gap_lsb_to_next", lc1[2] - lc1[1], 4);
        end

        // reset right after an MSB strobe, then loopback stream
        send(0, 16'hCAFE); v0 = 1'b0;
        step();
        chk("pre_reset_msb", bo0, 8'hCA);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bv0, 1'b0); chk("midrst_byte", bo0, 8'h00);
        chk("midrst_ready", rdy0, 1'b1); chk("midrst_level", lvl0, 3'd0);
        chk("midrst_busy", busy0, 1'b0);
        n0 = lg0.size();
        step(); step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("no_lsb_after_reset", lg0.size(), n0);
        rx_q.delete();
        send(0, 16'h1234); send(0, 16'hFFFF); v0 = 1'b0;
        drain();
        chk("rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("rx_sample0", rx_q[0], 16'h1234);
            chk("rx_sample1", rx_q[1], 16'hFFFF);
        end

        // randomized traffic on both instances, with one reset in the middle
        for (int c = 0; c < 500; c++) begin
            if (c == 250) begin
                rst_n = 1'b0;
                step(); step();
                rst_n = 1'b1;
            end
            if (v0 && acc[0]) v0 = 1'b0;
            if (v1 && acc[1]) v1 = 1'b0;
            if (!v0 && ($urandom_range(0, 2) != 0)) begin v0 = 1'b1; d0 = 16'($urandom); end
            if (!v1 && ($urandom_range(0, 1) != 0)) begin v1 = 1'b1; d1 = 16'($urandom); end
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        drain();
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_byte_tx.md
# sample_byte_tx

Byte-serial sample transmitter: the sending end of the two-byte, MSB-first sample link whose receiver assembles 16-bit samples from an 8-bit bus qualified by a single-cycle byte strobe. It accepts 16-bit samples over a valid/ready handshake and buffers them in a small FIFO. Each sample is then emitted as two strobed bytes, MSB first, with an optional idle gap between strobes. It serves as the host-side/loopback driver for the processing chain and as the template for streaming results off-chip.

## Interface
- DATA_WIDTH, 16: sample width; only 16 is supported (two bytes).
- FIFO_DEPTH, 4: sample FIFO depth; power of two, at least 2.
- GAP_CYCLES, 0: idle cycles inserted after every byte strobe; 0 to 15.

- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_in  input  16  sample to transmit.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  FIFO can accept; equals FIFO not full.
- byte_out  output  8  transmitted byte (registered).
- byte_valid  output  1  one-cycle strobe qualifying byte_out (registered).
- sample_done  output  1  one-cycle pulse coincident with the LSB strobe.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  samples currently buffered.

## Operation
- Push: a sample is accepted on any rising edge with sample_valid=1 and sample_ready=1. sample_valid while sample_ready=0 is ignored; the source must hold.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop and go to MSB.
  - MSB: byte_out=sample[15:8] and byte_valid=1 for exactly one cycle. Go to GAP_HI if GAP_CYCLES>0, else LSB.
  - GAP_HI: byte_valid=0 for GAP_CYCLES cycles, then go to LSB.
  - LSB: byte_out=sample[7:0], byte_valid=1 and sample_done=1 for one cycle. Go to GAP_LO if GAP_CYCLES>0, else go to the IDLE decision (pop and go to MSB if the FIFO is non-empty).
  - GAP_LO: byte_valid=0 for GAP_CYCLES cycles, then the IDLE decision.
- The popped sample is held in a 16-bit holding register. The FIFO entry is freed at the pop edge.
- byte_out keeps the last transmitted byte while byte_valid=0.
- A push and a pop on the same edge are both performed; fifo_level is unchanged.
- A strobe is never more than one cycle wide. The receiver counts strobes, so each sample always produces exactly two strobes, except when reset intervenes.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level saturates naturally at FIFO_DEPTH because sample_ready=0 when full.

## Timing
- Reset values (asynchronous, while rst_n=0): FSM=IDLE, FIFO empty, fifo_level=0, byte_out=8'h00, byte_valid=0, sample_done=0, busy=0, sample_ready=1.
- Reset mid-frame aborts the sample in flight: no remaining strobes are emitted and buffered samples are discarded. The downstream receiver must also be reset to keep byte alignment.
- Latency: a sample accepted at edge E into an empty, idle block has its MSB strobe registered at edge E+1. Its LSB strobe is registered at edge E+2+GAP_CYCLES.
- Strobe spacing:
  - MSB to LSB: GAP_CYCLES+1 cycles.
  - LSB to next MSB: GAP_CYCLES+1 cycles, when the FIFO is non-empty.
  - Throughput: one sample per 2·(GAP_CYCLES+1) cycles.
  - With GAP_CYCLES=0, strobes may be continuous (MSB, LSB, MSB, ...).
- sample_ready is combinational from fifo_level and falls in the cycle after the edge that fills the FIFO.
- busy deasserts in the cycle after the final strobe (GAP_CYCLES=0) or after GAP_LO completes.

## Test plan
- Reset: assert rst_n=0 mid-run -> all outputs at their reset values immediately; after release, sample_ready=1 and fifo_level=0.
- Single sample: push 16'hA55A at edge E, GAP_CYCLES=0 -> byte_valid with 8'hA5 at E+1, 8'h5A at E+2 with sample_done=1; byte_valid=0 and busy=0 from E+3.
- Back-to-back: push 16'h0102, 16'h0304, 16'h0506, 16'h0708 on consecutive cycles -> eight contiguous strobes 01,02,03,04,05,06,07,08; sample_done on every second strobe; no FIFO overflow.
- Backpressure: FIFO_DEPTH=4 with sample_valid held high and 6 samples offered -> sample_ready drops when fifo_level=4; no sample lost or duplicated; bytes emerge in push order.
- Gap: GAP_CYCLES=3, push 16'hBEEF -> 8'hBE strobe, 3 idle cycles, 8'hEF strobe; next sample MSB strobe no earlier than 4 cycles after the EF strobe.
- Reset mid-frame plus loopback: drive the receiver from byte_out/byte_valid. Reset both after an MSB strobe -> no LSB strobe is emitted. Then stream 16'h1234 and 16'hFFFF -> the receiver's reassembled samples equal the inputs with its write strobe on each LSB.
